pipeline_memory_stage: RTL
==========================

# pipeline_memory_stage

Memory-stage access controller sitting between the EX/MEM latch and the MEM/WB latch. Turns the MEM-stage load/store controls into datapath-cache requests and holds each request until `dhit`. Stalls the pipeline while an access is outstanding, and keeps completed load data stable until the MEM/WB latch advances. Optionally implements the LL/SC link register.

## Interface
- No parameters. Widths are fixed by `word_t` (32 bit).
- `CLK  in  1  clock`
- `nRST  in  1  reset, asynchronous, active-low`
- `valid_mem  in  1  MEM-stage holds a real (non-bubble) instruction`
- `MemRead_mem  in  1  load (includes LL)`
- `MemWrite_mem  in  1  store (includes SC)`
- `ll_mem  in  1  load-linked`
- `sc_mem  in  1  store-conditional`
- `addr_mem  in  32  effective address from EX/MEM`
- `store_mem  in  32  store data from EX/MEM`
- `advance  in  1  MEM/WB latch is in PIPE_ENABLE this cycle`
- `dhit  in  1  cache completed current request`
- `dload  in  32  cache read data`
- `dREN  out  1  cache read request`
- `dWEN  out  1  cache write request`
- `daddr  out  32  cache address`
- `dstore  out  32  cache write data`
- `mem_busy  out  1  to hazard unit: freeze PC..EX/MEM, NOP into MEM/WB`
- `dmemload_mem  out  32  load data (or SC result) toward MEM/WB`
- `stall_cycles  out  32  saturating count of mem_busy cycles`

## Operation
- `memop = valid_mem & (MemRead_mem | MemWrite_mem) & ~sc_fail`.
- `sc_fail` is 0 when LLSC_EN is undefined.
- FSM states `MS_IDLE`, `MS_WAIT`, `MS_HOLD`.
- **MS_IDLE**
  - `dREN = memop & MemRead_mem`; `dWEN = memop & MemWrite_mem`. Both are combinational, issued in the same cycle the instruction enters MEM.
  - `memop & ~dhit` → MS_WAIT.
  - `memop & dhit & ~advance` → MS_HOLD, capturing `dload` into the hold register.
  - `memop & dhit & advance` → stay in MS_IDLE.
- **MS_WAIT**
  - Keeps the same request asserted; `daddr`/`dstore` are driven from `addr_mem`/`store_mem`, which are frozen by the stall.
  - Transitions on `dhit`/`advance` are identical to MS_IDLE.
- **MS_HOLD**
  - `dREN = dWEN = 0`, so the access is never repeated.
  - `dmemload_mem` is driven from the hold register.
  - `advance` → MS_IDLE.
- `mem_busy = (state != MS_HOLD) & memop & ~dhit`.
- `dmemload_mem` output mux:
  - MS_HOLD: hold register.
  - SC: the SC result.
  - Otherwise: `dload` pass-through.
- `stall_cycles` increments on every cycle with `mem_busy`=1 and saturates at 0xFFFF_FFFF.
- No address-alignment checking: `daddr = addr_mem` unmodified.

## Timing
- Hit latency 0: a same-cycle `dhit` means no stall, and the data is latched by MEM/WB at that edge.
- Miss of N cycles: `mem_busy` is high for exactly N cycles.
- `dhit` while `dREN=dWEN=0` is ignored.
- `advance` with no memop has no effect.
- **Reset (async):**
  - State → MS_IDLE.
  - Hold register, `stall_cycles`, and link register cleared.
  - `dREN`/`dWEN` drop immediately, and `mem_busy` drops with them.
- Reset mid-MS_WAIT abandons the request; the cache is reset by the same nRST.

## Configuration
- **`LLSC_EN` defined**
  - Link register `{link_valid, link_addr[31:2]}`.
  - LL completing (dhit) sets `link_valid=1`, `link_addr=addr_mem[31:2]`.
  - `sc_fail = sc_mem & ~(link_valid & link_addr==addr_mem[31:2])`.
  - A failing SC issues no request, produces no stall, and returns `dmemload_mem=0`.
  - A succeeding SC writes normally and returns 1 on completion.
  - Any completing store (SW or SC) to the linked word clears `link_valid`.
  - A completing SC clears `link_valid` regardless of address.
- **`LLSC_EN` undefined:** LL behaves as LW and SC behaves as SW, with `dmemload_mem` undefined (don't-care) for SC. No link register is built.

## Structure
- `memstate_t` enum (MS_IDLE/MS_WAIT/MS_HOLD) goes in `cpu_types_pkg`, next to the existing `PIPE_ENABLE`/`PIPE_NOP` pipe-state type.
- `word_t` comes from `cpu_types_pkg`.
- One sub-module, `llsc_link_reg`, holding the link register and match logic. It is instantiated only under `LLSC_EN`.

## Test plan
- LW to 0x100 with `dhit` same cycle, `advance`=1 → `mem_busy` never asserts, `dmemload_mem`=`dload`=0xDEADBEEF at the edge, FSM stays in MS_IDLE.
- SW to 0x200 with `dhit` after 3 cycles → `dWEN` is high for 4 cycles, `mem_busy` is high for 3, `stall_cycles`=3.
- LW hit with `advance`=0 for 2 cycles → `dREN` drops after the hit, `dmemload_mem` holds 0x12345678 across both cycles, and the state returns to MS_IDLE when `advance`=1.
- nRST asserted during MS_WAIT → `dREN`, `mem_busy` and `stall_cycles` are 0 immediately, state is MS_IDLE.
- LLSC_EN: LL 0x300, then SC 0x300 → SC writes and returns 1. A second SC to 0x300 → no `dWEN`, returns 0.
- LLSC_EN: LL 0x300, SW 0x300, then SC 0x300 → SC fails, returns 0, `mem_busy` stays 0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared CPU datapath types: word, pipe-latch state, MEM-stage FSM state
package cpu_types_pkg;

    localparam int WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    // Pipeline latch control
    typedef enum logic {
        PIPE_ENABLE,
        PIPE_NOP
    } pipe_state_t;

    // Memory-stage access controller
    typedef enum logic [1:0] {
        MS_IDLE,
        MS_WAIT,
        MS_HOLD
    } memstate_t;

endpackage

// File: rtl/llsc_link_reg.sv
// rtl/llsc_link_reg.sv - LL/SC link register and store-conditional match logic
//
// Ports:
//   CLK, nRST      clock, asynchronous active-low reset
//   sc_mem         MEM-stage instruction is a store-conditional
//   addr_mem       effective address of the MEM-stage access
//   ll_done        a load-linked completes this cycle
//   st_done        any store (SW or SC) completes this cycle
//   sc_done        a store-conditional completes this cycle
//   sc_fail        SC in MEM does not match a valid link
module llsc_link_reg
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  sc_mem,
    input  word_t addr_mem,
    input  logic  ll_done,
    input  logic  st_done,
    input  logic  sc_done,
    output logic  sc_fail
);

    logic        link_valid;
    logic [29:0] link_addr;
    logic        link_match;
    logic        unused_byte_bits;

    // Links are word-granular; byte offset does not take part in the match.
    assign unused_byte_bits = ^addr_mem[1:0];

    assign link_match = link_valid & (link_addr == addr_mem[31:2]);
    assign sc_fail    = sc_mem & ~link_match;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            link_valid <= 1'b0;
            link_addr  <= '0;
        end else if (ll_done) begin
            link_valid <= 1'b1;
            link_addr  <= addr_mem[31:2];
        end else if (sc_done || (st_done && link_match)) begin
            // Any completed SC consumes the link; a plain store kills it only
            // when it hits the linked word.
            link_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipeline_memory_stage.sv
// rtl/pipeline_memory_stage.sv - MEM-stage cache access controller with stall and load-data hold
//
// Optional feature macro: LLSC_EN (builds the LL/SC link register).
//
// Ports:
//   CLK, nRST                      clock, asynchronous active-low reset
//   valid_mem                      MEM stage holds a real instruction
//   MemRead_mem, MemWrite_mem      load / store controls (include LL / SC)
//   ll_mem, sc_mem                 load-linked / store-conditional
//   addr_mem, store_mem            address and store data from EX/MEM
//   advance                        MEM/WB latch enabled this cycle
//   dhit, dload                    cache completion and read data
//   dREN, dWEN, daddr, dstore      cache request
//   mem_busy                       stall request to the hazard unit
//   dmemload_mem                   load data (or SC result) toward MEM/WB
//   stall_cycles                   saturating count of mem_busy cycles
module pipeline_memory_stage
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  nRST,
    input  logic  valid_mem,
    input  logic  MemRead_mem,
    input  logic  MemWrite_mem,
    input  logic  ll_mem,
    input  logic  sc_mem,
    input  word_t addr_mem,
    input  word_t store_mem,
    input  logic  advance,
    input  logic  dhit,
    input  word_t dload,
    output logic  dREN,
    output logic  dWEN,
    output word_t daddr,
    output word_t dstore,
    output logic  mem_busy,
    output word_t dmemload_mem,
    output word_t stall_cycles
);

    memstate_t state, next_state;
    word_t     hold_reg;
    word_t     result;
    logic      sc_fail;
    logic      memop;
    logic      req_live;
    logic      complete;

    assign memop    = valid_mem & (MemRead_mem | MemWrite_mem) & ~sc_fail;
    // In MS_HOLD the access already completed; never reissue it.
    assign req_live = (state != MS_HOLD) & memop;
    assign complete = req_live & dhit;

`ifdef LLSC_EN
    llsc_link_reg u_link (
        .CLK      (CLK),
        .nRST     (nRST),
        .sc_mem   (sc_mem),
        .addr_mem (addr_mem),
        .ll_done  (complete & MemRead_mem & ll_mem),
        .st_done  (complete & MemWrite_mem),
        .sc_done  (complete & sc_mem),
        .sc_fail  (sc_fail)
    );

    // A failing SC issues no request (memop=0), so it reports 0 at once.
    assign result = sc_mem ? {{(WORD_W-1){1'b0}}, ~sc_fail} : dload;
`else
    logic unused_llsc;
    assign unused_llsc = ll_mem ^ sc_mem;
    assign sc_fail     = 1'b0;
    assign result      = dload;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= MS_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            MS_IDLE, MS_WAIT: begin
                if (!memop) begin
                    next_state = MS_IDLE;
                end else if (!dhit) begin
                    next_state = MS_WAIT;
                end else if (!advance) begin
                    next_state = MS_HOLD;
                end else begin
                    next_state = MS_IDLE;
                end
            end
            MS_HOLD: begin
                if (advance) begin
                    next_state = MS_IDLE;
                end
            end
            default: next_state = MS_IDLE;
        endcase
    end

    // Requests and the stall are gated by nRST so they drop the moment reset
    // asserts, not at the next state update.
    assign dREN     = nRST & req_live & MemRead_mem;
    assign dWEN     = nRST & req_live & MemWrite_mem;
    assign mem_busy = nRST & req_live & ~dhit;
    assign daddr    = addr_mem;
    assign dstore   = store_mem;

    assign dmemload_mem = (state == MS_HOLD) ? hold_reg : result;

    // Captures the completed result when MEM/WB cannot take it this edge.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            hold_reg <= '0;
        end else if (complete && !advance) begin
            hold_reg <= result;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cycles <= '0;
        end else if (mem_busy && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule
